scr1_pipe_ialu: RTL and testbench

SCR1_PIPE_IALU -- requirements
Module: scr1_pipe_ialu

---
 rtl/scr1_riscv_isa_decoding_pkg.sv | 44 ++++
 rtl/scr1_ialu_div.sv | 82 ++++++++
 rtl/scr1_pipe_ialu.sv | 155 +++++++++++++++
 tb/tb_scr1_pipe_ialu.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_riscv_isa_decoding_pkg.sv
// Shared IALU types: command encoding, SUB flags, divider FSM states and XLEN.
package scr1_riscv_isa_decoding_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [4:0] {
    SCR1_IALU_CMD_NONE    = 5'd0,
    SCR1_IALU_CMD_AND     = 5'd1,
    SCR1_IALU_CMD_OR      = 5'd2,
    SCR1_IALU_CMD_XOR     = 5'd3,
    SCR1_IALU_CMD_ADD     = 5'd4,
    SCR1_IALU_CMD_SUB     = 5'd5,
    SCR1_IALU_CMD_SUB_LT  = 5'd6,
    SCR1_IALU_CMD_SUB_LTU = 5'd7,
    SCR1_IALU_CMD_SUB_EQ  = 5'd8,
    SCR1_IALU_CMD_SUB_NE  = 5'd9,
    SCR1_IALU_CMD_SUB_GE  = 5'd10,
    SCR1_IALU_CMD_SUB_GEU = 5'd11,
    SCR1_IALU_CMD_SLL     = 5'd12,
    SCR1_IALU_CMD_SRL     = 5'd13,
    SCR1_IALU_CMD_SRA     = 5'd14,
    SCR1_IALU_CMD_MUL     = 5'd15,
    SCR1_IALU_CMD_MULH    = 5'd16,
    SCR1_IALU_CMD_MULHSU  = 5'd17,
    SCR1_IALU_CMD_MULHU   = 5'd18,
    SCR1_IALU_CMD_DIV     = 5'd19,
    SCR1_IALU_CMD_DIVU    = 5'd20,
    SCR1_IALU_CMD_REM     = 5'd21,
    SCR1_IALU_CMD_REMU    = 5'd22
  } type_scr1_ialu_cmd_sel_e;

  typedef struct packed {
    logic z;
    logic s;
    logic o;
    logic c;
  } type_scr1_ialu_flags_s;

  typedef enum logic {
    SCR1_DIV_FSM_IDLE = 1'b0,
    SCR1_DIV_FSM_DIV  = 1'b1
  } type_scr1_div_fsm_e;

endpackage

// File: rtl/scr1_ialu_div.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// signs corrected on the final combinational step.
module scr1_ialu_div
  import scr1_riscv_isa_decoding_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            sgn,
  input  logic            rem_sel,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            rdy,
  output logic [XLEN-1:0] res
);

  type_scr1_div_fsm_e state;
  logic [4:0]         cnt;
  logic [XLEN-1:0]    prem;
  logic [XLEN-1:0]    quo;

  logic            dvd_neg;
  logic            dvs_neg;
  logic [XLEN-1:0] dvd_mag;
  logic [XLEN-1:0] dvs_mag;
  logic [XLEN:0]   trial;
  logic            qbit;
  logic [XLEN-1:0] prem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  assign dvd_neg = sgn & op1[XLEN-1];
  assign dvs_neg = sgn & op2[XLEN-1];
  assign dvd_mag = dvd_neg ? (~op1 + 32'd1) : op1;
  assign dvs_mag = dvs_neg ? (~op2 + 32'd1) : op2;

  // Trial subtraction of the divisor from the shifted partial remainder
  assign trial    = {prem, quo[XLEN-1]} - {1'b0, dvs_mag};
  assign qbit     = ~trial[XLEN];
  assign prem_nxt = qbit ? trial[XLEN-1:0] : {prem[XLEN-2:0], quo[XLEN-1]};
  assign quo_nxt  = {quo[XLEN-2:0], qbit};

  assign quo_fix = (op2 == '0)           ? '1 :
                   (dvd_neg ^ dvs_neg)   ? (~quo_nxt + 32'd1) : quo_nxt;
  assign rem_fix = dvd_neg ? (~prem_nxt + 32'd1) : prem_nxt;

  assign rdy = req & (state == SCR1_DIV_FSM_DIV) & (cnt == 5'd0);
  assign res = rem_sel ? rem_fix : quo_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCR1_DIV_FSM_IDLE;
      cnt   <= 5'd0;
      prem  <= '0;
      quo   <= '0;
    end else begin
      case (state)
        SCR1_DIV_FSM_IDLE: begin
          if (req) begin
            state <= SCR1_DIV_FSM_DIV;
            cnt   <= 5'd31;
            prem  <= '0;
            quo   <= dvd_mag;
          end
        end
        SCR1_DIV_FSM_DIV: begin
          // Abort on dropped request; the final bit lives only on the rdy cycle
          if (!req || (cnt == 5'd0)) begin
            state <= SCR1_DIV_FSM_IDLE;
          end else begin
            cnt  <= cnt - 5'd1;
            prem <= prem_nxt;
            quo  <= quo_nxt;
          end
        end
        default: state <= SCR1_DIV_FSM_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/scr1_pipe_ialu.sv
// Integer ALU: logic/arith/compare/shift, address adder and optional MUL/DIV.
// Optional RV32M support is enabled by defining SCR1_IALU_RVM_EN.
module scr1_pipe_ialu
  import scr1_riscv_isa_decoding_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    exu2ialu_rvm_cmd_vd_i,
  output logic                    ialu2exu_rvm_res_rdy_o,
  input  logic [XLEN-1:0]         exu2ialu_main_op1_i,
  input  logic [XLEN-1:0]         exu2ialu_main_op2_i,
  input  type_scr1_ialu_cmd_sel_e exu2ialu_cmd_i,
  output logic [XLEN-1:0]         ialu2exu_main_res_o,
  output logic                    ialu2exu_cmp_res_o,
  input  logic [XLEN-1:0]         exu2ialu_addr_op1_i,
  input  logic [XLEN-1:0]         exu2ialu_addr_op2_i,
  output logic [XLEN-1:0]         ialu2exu_addr_res_o
);

  logic [XLEN-1:0]       op1;
  logic [XLEN-1:0]       op2;
  logic [XLEN:0]         sub_full;
  logic [XLEN-1:0]       sub_res;
  type_scr1_ialu_flags_s flags;
  logic [4:0]            shamt;
  logic [XLEN-1:0]       sra_res;

  assign op1 = exu2ialu_main_op1_i;
  assign op2 = exu2ialu_main_op2_i;

  assign ialu2exu_addr_res_o = exu2ialu_addr_op1_i + exu2ialu_addr_op2_i;

  // Single subtractor feeds SUB and every comparison; bit XLEN is the borrow
  assign sub_full = {1'b0, op1} - {1'b0, op2};
  assign sub_res  = sub_full[XLEN-1:0];

  always_comb begin
    flags   = '0;
    flags.z = (sub_res == '0);
    flags.s = sub_res[XLEN-1];
    flags.o = (op1[XLEN-1] ^ op2[XLEN-1]) & (op1[XLEN-1] ^ sub_res[XLEN-1]);
    flags.c = sub_full[XLEN];
  end

  assign shamt   = op2[4:0];
  assign sra_res = 32'($signed(op1) >>> shamt);

`ifdef SCR1_IALU_RVM_EN
  logic            vd;
  logic [63:0]     mul_a;
  logic [63:0]     mul_b;
  logic [63:0]     mul_prod;
  logic            op1_sgn;
  logic            op2_sgn;
  logic            div_cmd;
  logic            div_sgn;
  logic            div_rem;
  logic            div_rdy;
  logic [XLEN-1:0] div_res;

  assign vd = exu2ialu_rvm_cmd_vd_i;

  // Sign-extended 64-bit operands make one unsigned multiplier serve all variants
  assign op1_sgn  = (exu2ialu_cmd_i == SCR1_IALU_CMD_MULH) | (exu2ialu_cmd_i == SCR1_IALU_CMD_MULHSU);
  assign op2_sgn  = (exu2ialu_cmd_i == SCR1_IALU_CMD_MULH);
  assign mul_a    = {{32{op1_sgn & op1[XLEN-1]}}, op1};
  assign mul_b    = {{32{op2_sgn & op2[XLEN-1]}}, op2};
  assign mul_prod = mul_a * mul_b;

  assign div_cmd = (exu2ialu_cmd_i == SCR1_IALU_CMD_DIV)  | (exu2ialu_cmd_i == SCR1_IALU_CMD_DIVU) |
                   (exu2ialu_cmd_i == SCR1_IALU_CMD_REM)  | (exu2ialu_cmd_i == SCR1_IALU_CMD_REMU);
  assign div_sgn = (exu2ialu_cmd_i == SCR1_IALU_CMD_DIV)  | (exu2ialu_cmd_i == SCR1_IALU_CMD_REM);
  assign div_rem = (exu2ialu_cmd_i == SCR1_IALU_CMD_REM)  | (exu2ialu_cmd_i == SCR1_IALU_CMD_REMU);

  scr1_ialu_div i_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (vd & div_cmd),
    .sgn     (div_sgn),
    .rem_sel (div_rem),
    .op1     (op1),
    .op2     (op2),
    .rdy     (div_rdy),
    .res     (div_res)
  );
`else
  logic unused_rvm;
  assign unused_rvm = ^{clk, rst_n, exu2ialu_rvm_cmd_vd_i};
`endif

  always_comb begin
    ialu2exu_main_res_o    = '0;
    ialu2exu_cmp_res_o     = 1'b0;
    ialu2exu_rvm_res_rdy_o = 1'b0;
    case (exu2ialu_cmd_i)
      SCR1_IALU_CMD_AND:     ialu2exu_main_res_o = op1 & op2;
      SCR1_IALU_CMD_OR:      ialu2exu_main_res_o = op1 | op2;
      SCR1_IALU_CMD_XOR:     ialu2exu_main_res_o = op1 ^ op2;
      SCR1_IALU_CMD_ADD:     ialu2exu_main_res_o = op1 + op2;
      SCR1_IALU_CMD_SUB:     ialu2exu_main_res_o = sub_res;
      SCR1_IALU_CMD_SUB_LT: begin
        ialu2exu_cmp_res_o  = flags.s ^ flags.o;
        ialu2exu_main_res_o = {31'b0, flags.s ^ flags.o};
      end
      SCR1_IALU_CMD_SUB_LTU: begin
        ialu2exu_cmp_res_o  = flags.c;
        ialu2exu_main_res_o = {31'b0, flags.c};
      end
      SCR1_IALU_CMD_SUB_EQ: begin
        ialu2exu_cmp_res_o  = flags.z;
        ialu2exu_main_res_o = sub_res;
      end
      SCR1_IALU_CMD_SUB_NE: begin
        ialu2exu_cmp_res_o  = ~flags.z;
        ialu2exu_main_res_o = sub_res;
      end
      SCR1_IALU_CMD_SUB_GE: begin
        ialu2exu_cmp_res_o  = ~(flags.s ^ flags.o);
        ialu2exu_main_res_o = sub_res;
      end
      SCR1_IALU_CMD_SUB_GEU: begin
        ialu2exu_cmp_res_o  = ~flags.c;
        ialu2exu_main_res_o = sub_res;
      end
      SCR1_IALU_CMD_SLL:     ialu2exu_main_res_o = op1 << shamt;
      SCR1_IALU_CMD_SRL:     ialu2exu_main_res_o = op1 >> shamt;
      SCR1_IALU_CMD_SRA:     ialu2exu_main_res_o = sra_res;
`ifdef SCR1_IALU_RVM_EN
      SCR1_IALU_CMD_MUL: begin
        ialu2exu_main_res_o    = mul_prod[31:0];
        ialu2exu_rvm_res_rdy_o = vd;
      end
      SCR1_IALU_CMD_MULH,
      SCR1_IALU_CMD_MULHSU,
      SCR1_IALU_CMD_MULHU: begin
        ialu2exu_main_res_o    = mul_prod[63:32];
        ialu2exu_rvm_res_rdy_o = vd;
      end
      SCR1_IALU_CMD_DIV,
      SCR1_IALU_CMD_DIVU,
      SCR1_IALU_CMD_REM,
      SCR1_IALU_CMD_REMU: begin
        ialu2exu_main_res_o    = div_res;
        ialu2exu_rvm_res_rdy_o = div_rdy;
      end
`endif
      default: begin
        ialu2exu_main_res_o    = '0;
        ialu2exu_cmp_res_o     = 1'b0;
        ialu2exu_rvm_res_rdy_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_scr1_pipe_ialu.sv
// Directed self-checking bench for scr1_pipe_ialu (both SCR1_IALU_RVM_EN builds).
module tb_scr1_pipe_ialu;
  import scr1_riscv_isa_decoding_pkg::*;

  logic                    clk;
  logic                    rst_n;
  logic                    vd;
  logic                    rdy;
  logic [31:0]             op1;
  logic [31:0]             op2;
  type_scr1_ialu_cmd_sel_e cmd;
  logic [31:0]             main_res;
  logic                    cmp_res;
  logic [31:0]             aop1;
  logic [31:0]             aop2;
  logic [31:0]             addr_res;

  int total = 0;
  int bad   = 0;

  scr1_pipe_ialu dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .exu2ialu_rvm_cmd_vd_i  (vd),
    .ialu2exu_rvm_res_rdy_o (rdy),
    .exu2ialu_main_op1_i    (op1),
    .exu2ialu_main_op2_i    (op2),
    .exu2ialu_cmd_i         (cmd),
    .ialu2exu_main_res_o    (main_res),
    .ialu2exu_cmp_res_o     (cmp_res),
    .exu2ialu_addr_op1_i    (aop1),
    .exu2ialu_addr_op2_i    (aop2),
    .ialu2exu_addr_res_o    (addr_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input type_scr1_ialu_cmd_sel_e c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    cmd = c;
    op1 = a;
    op2 = b;
    #1;
  endtask

  // Start a divide at a negedge, hold vd, return the rdy latency in cycles (0 = timeout)
  task automatic div_run(input type_scr1_ialu_cmd_sel_e c, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output logic [31:0] res);
    @(negedge clk);
    cmd = c;
    op1 = a;
    op2 = b;
    vd  = 1'b1;
    cycles = 0;
    res    = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        cycles = k;
        res    = main_res;
        break;
      end
    end
    @(negedge clk);
    vd = 1'b0;
    @(negedge clk);
  endtask

  int          cyc;
  logic [31:0] r;

  initial begin
    rst_n = 1'b0;
    vd    = 1'b0;
    cmd   = SCR1_IALU_CMD_NONE;
    op1   = 32'h1234_5678;
    op2   = 32'h0000_0001;
    aop1  = 32'h0000_1000;
    aop2  = 32'h0000_0FFC;
    #12;
    check("reset_rdy", {31'b0, rdy}, 32'h0);
    check("reset_none_res", main_res, 32'h0);
    check("reset_none_cmp", {31'b0, cmp_res}, 32'h0);
    check("reset_addr", addr_res, 32'h0000_1FFC);
    @(negedge clk);
    rst_n = 1'b1;

    apply(SCR1_IALU_CMD_ADD, 32'hFFFF_FFFF, 32'h1);
    check("add_wrap", main_res, 32'h0);
    aop1 = 32'hFFFF_FFF0;
    aop2 = 32'h0000_0020;
    #1;
    check("addr_wrap", addr_res, 32'h0000_0010);
    apply(SCR1_IALU_CMD_SUB, 32'h0, 32'h1);
    check("sub_wrap", main_res, 32'hFFFF_FFFF);
    apply(SCR1_IALU_CMD_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("and", main_res, 32'h00F0_00F0);
    apply(SCR1_IALU_CMD_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("or", main_res, 32'hFFF0_FFF0);
    apply(SCR1_IALU_CMD_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("xor", main_res, 32'hFF00_FF00);
    check("xor_cmp", {31'b0, cmp_res}, 32'h0);

    apply(SCR1_IALU_CMD_SUB_LT, 32'hFFFF_FFFF, 32'h1);
    check("lt_cmp", {31'b0, cmp_res}, 32'h1);
    check("lt_res", main_res, 32'h1);
    apply(SCR1_IALU_CMD_SUB_LTU, 32'hFFFF_FFFF, 32'h1);
    check("ltu_cmp", {31'b0, cmp_res}, 32'h0);
    check("ltu_res", main_res, 32'h0);
    apply(SCR1_IALU_CMD_SUB_EQ, 32'h5, 32'h5);
    check("eq_cmp", {31'b0, cmp_res}, 32'h1);
    check("eq_res", main_res, 32'h0);
    apply(SCR1_IALU_CMD_SUB_NE, 32'h5, 32'h5);
    check("ne_cmp", {31'b0, cmp_res}, 32'h0);
    apply(SCR1_IALU_CMD_SUB_GE, 32'h7FFF_FFFF, 32'h8000_0000);
    check("ge_ovf_cmp", {31'b0, cmp_res}, 32'h1);
    check("ge_ovf_res", main_res, 32'hFFFF_FFFF);
    apply(SCR1_IALU_CMD_SUB_LT, 32'h7FFF_FFFF, 32'h8000_0000);
    check("lt_ovf_cmp", {31'b0, cmp_res}, 32'h0);
    apply(SCR1_IALU_CMD_SUB_GEU, 32'h1, 32'h2);
    check("geu_cmp", {31'b0, cmp_res}, 32'h0);
    check("geu_res", main_res, 32'hFFFF_FFFF);

    apply(SCR1_IALU_CMD_SRA, 32'h8000_0000, 32'h24);
    check("sra", main_res, 32'hF800_0000);
    apply(SCR1_IALU_CMD_SRL, 32'h8000_0000, 32'h1F);
    check("srl", main_res, 32'h1);
    apply(SCR1_IALU_CMD_SLL, 32'h1, 32'h3F);
    check("sll", main_res, 32'h8000_0000);

    vd = 1'b1;
`ifdef SCR1_IALU_RVM_EN
    apply(SCR1_IALU_CMD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhu_rdy", {31'b0, rdy}, 32'h1);
    check("mulhu_res", main_res, 32'hFFFF_FFFE);
    apply(SCR1_IALU_CMD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mul_res", main_res, 32'h1);
    apply(SCR1_IALU_CMD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulh_res", main_res, 32'h0);
    apply(SCR1_IALU_CMD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhsu_res", main_res, 32'hFFFF_FFFF);
    vd = 1'b0;
    #1;
    check("mul_novd_rdy", {31'b0, rdy}, 32'h0);
    apply(SCR1_IALU_CMD_ADD, 32'h1, 32'h1);
    vd = 1'b1;
    #1;
    check("add_vd_rdy", {31'b0, rdy}, 32'h0);
    vd = 1'b0;

    div_run(SCR1_IALU_CMD_DIV, 32'hFFFF_FFF9, 32'h2, cyc, r);
    check("div_lat", 32'(cyc), 32'd32);
    check("div_res", r, 32'hFFFF_FFFD);
    div_run(SCR1_IALU_CMD_REM, 32'hFFFF_FFF9, 32'h2, cyc, r);
    check("rem_res", r, 32'hFFFF_FFFF);
    div_run(SCR1_IALU_CMD_DIVU, 32'd10, 32'd0, cyc, r);
    check("divu0_lat", 32'(cyc), 32'd32);
    check("divu0_res", r, 32'hFFFF_FFFF);
    div_run(SCR1_IALU_CMD_REM, 32'hFFFF_FFF6, 32'd0, cyc, r);
    check("rem0_res", r, 32'hFFFF_FFF6);
    div_run(SCR1_IALU_CMD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, r);
    check("div_ovf_res", r, 32'h8000_0000);
    div_run(SCR1_IALU_CMD_REM, 32'h8000_0000, 32'hFFFF_FFFF, cyc, r);
    check("rem_ovf_res", r, 32'h0);
    div_run(SCR1_IALU_CMD_DIVU, 32'd100, 32'd7, cyc, r);
    check("divu_res", r, 32'd14);
    div_run(SCR1_IALU_CMD_REMU, 32'hFFFF_FFFF, 32'd7, cyc, r);
    check("remu_res", r, 32'd3);

    // Reset mid-division, then a clean divide must still take 32 cycles
    @(negedge clk);
    cmd = SCR1_IALU_CMD_DIV;
    op1 = 32'd100;
    op2 = 32'd3;
    vd  = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_rdy", {31'b0, rdy}, 32'h0);
    @(negedge clk);
    vd    = 1'b0;
    rst_n = 1'b1;
    div_run(SCR1_IALU_CMD_DIV, 32'hFFFF_FFF9, 32'h2, cyc, r);
    check("after_rst_lat", 32'(cyc), 32'd32);
    check("after_rst_res", r, 32'hFFFF_FFFD);

    // Dropping vd mid-division aborts; a restart counts from scratch
    @(negedge clk);
    cmd = SCR1_IALU_CMD_DIVU;
    op1 = 32'd100;
    op2 = 32'd3;
    vd  = 1'b1;
    repeat (5) @(negedge clk);
    vd = 1'b0;
    #1;
    check("abort_rdy", {31'b0, rdy}, 32'h0);
    div_run(SCR1_IALU_CMD_DIVU, 32'd100, 32'd3, cyc, r);
    check("abort_restart_lat", 32'(cyc), 32'd32);
    check("abort_restart_res", r, 32'd33);
`else
    apply(SCR1_IALU_CMD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("norvm_mulhu_rdy", {31'b0, rdy}, 32'h0);
    check("norvm_mulhu_res", main_res, 32'h0);
    check("norvm_mulhu_cmp", {31'b0, cmp_res}, 32'h0);
    apply(SCR1_IALU_CMD_DIV, 32'hFFFF_FFF9, 32'h2);
    repeat (33) @(posedge clk);
    #1;
    check("norvm_div_rdy", {31'b0, rdy}, 32'h0);
    check("norvm_div_res", main_res, 32'h0);
    vd = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
